// File: rtl/md_control_unit.sv
// RV32 decode control unit: combinational main decode, ID/EX control register, and
// multi-cycle M-extension sequencing (built only when RV_M_EXT_EN is defined).
module md_control_unit #(
    parameter int ALU_CTRL_W = 4,
    parameter int MUL_LAT    = 2,
    parameter int DIV_LAT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_d,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  stall_e,
    input  logic                  flush_e,
    output logic [2:0]            imm_src_d,
    output logic                  busy_d,
    output logic                  valid_e,
    output logic                  reg_write_e,
    output logic                  mem_write_e,
    output logic                  jump_e,
    output logic                  branch_e,
    output logic                  alu_src_a_e,
    output logic                  alu_src_b_e,
    output logic                  adder_src_e,
    output logic [1:0]            res_src_e,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  md_start_e,
    output logic [2:0]            md_op_e,
    output logic                  illegal_e
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] F7_MD     = 7'b0000001;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] res_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       adder_src;
        logic [3:0] alu;
        logic       illegal;
    } ctrl_t;

    ctrl_t       ctrl_d, ctrl_e;
    logic [12:0] cw;
    logic        valid_q;
    logic        busy;
`ifdef RV_M_EXT_EN
    logic        is_md;
`endif

    // alt selects sub (register form only) and sra; funct7[5] is imm[10] for op-imm shifts
    function automatic logic [3:0] arith_alu(input logic [2:0] f3, input logic alt,
                                             input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && alt) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0010;
            3'b010:  return 4'b0011;
            3'b011:  return 4'b0100;
            3'b100:  return 4'b0101;
            3'b101:  return alt ? 4'b0111 : 4'b0110;
            3'b110:  return 4'b1000;
            default: return 4'b1001;
        endcase
    endfunction

    always_comb begin
        cw     = '0;
        ctrl_d = '0;
`ifdef RV_M_EXT_EN
        is_md  = 1'b0;
`endif
        case (op)
            OP_LOAD:  cw = 13'b1_01_0_0_0_0_1_0_000;
            OP_IMM: begin
                cw         = 13'b1_00_0_0_0_0_1_0_000;
                ctrl_d.alu = arith_alu(funct3, funct7[5], 1'b0);
            end
            OP_AUIPC: cw = 13'b1_00_0_0_0_1_1_0_100;
            OP_STORE: cw = 13'b0_01_1_0_0_0_1_0_001;
            OP_REG: begin
                if (funct7 == F7_MD) begin
`ifdef RV_M_EXT_EN
                    cw    = 13'b1_11_0_0_0_0_0_0_000;
                    is_md = 1'b1;
`else
                    ctrl_d.illegal = 1'b1;
`endif
                end else begin
                    cw         = 13'b1_00_0_0_0_0_0_0_000;
                    ctrl_d.alu = arith_alu(funct3, funct7[5], 1'b1);
                end
            end
            OP_LUI: begin
                cw         = 13'b1_00_0_0_0_0_0_0_100;
                ctrl_d.alu = 4'b1101;
            end
            OP_BRANCH: begin
                cw = 13'b0_00_0_0_1_0_0_0_010;
                case (funct3[2:1])
                    2'b00:   ctrl_d.alu = 4'b1010;
                    2'b10:   ctrl_d.alu = 4'b1011;
                    2'b11:   ctrl_d.alu = 4'b1100;
                    default: begin
                        ctrl_d.alu     = 4'b1010;
                        ctrl_d.illegal = 1'b1;
                    end
                endcase
            end
            OP_JALR:  cw = 13'b1_10_0_1_0_0_0_1_000;
            OP_JAL:   cw = 13'b1_10_0_1_0_0_0_0_011;
            default:  ctrl_d.illegal = 1'b1;
        endcase
        {ctrl_d.reg_write, ctrl_d.res_src, ctrl_d.mem_write, ctrl_d.jump, ctrl_d.branch,
         ctrl_d.alu_src_a, ctrl_d.alu_src_b, ctrl_d.adder_src} = cw[12:3];
        imm_src_d = cw[2:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_e  <= '0;
        end else if (flush_e) begin
            valid_q <= 1'b0;
            ctrl_e  <= '0;
        end else if (!(stall_e || busy)) begin
            valid_q <= valid_d;
            ctrl_e  <= valid_d ? ctrl_d : '0;
        end
    end

`ifdef RV_M_EXT_EN
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

    typedef enum logic {IDLE, MD_BUSY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, issue_cnt;
    logic             issue;
    logic             start_q;
    logic [2:0]       md_op_q;

    assign issue     = valid_d && is_md && !stall_e && (state == IDLE);
    assign issue_cnt = funct3[2] ? DIV_CNT : MUL_CNT;
    assign busy      = (state == MD_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Zero issue count means a single-cycle op: it never enters MD_BUSY
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush_e) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue && issue_cnt != '0) begin
                        state_nxt = MD_BUSY;
                        cnt_nxt   = issue_cnt;
                    end
                end
                MD_BUSY: begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            md_op_q <= '0;
        end else if (flush_e) begin
            start_q <= 1'b0;
            md_op_q <= '0;
        end else if (stall_e || busy) begin
            start_q <= 1'b0;
        end else begin
            start_q <= valid_d && is_md;
            md_op_q <= (valid_d && is_md) ? funct3 : 3'b000;
        end
    end

    assign md_start_e = start_q;
    assign md_op_e    = md_op_q;
`else
    assign busy       = 1'b0;
    assign md_start_e = 1'b0;
    assign md_op_e    = 3'b000;
`endif

    assign busy_d        = busy;
    assign valid_e       = valid_q;
    assign reg_write_e   = ctrl_e.reg_write;
    assign res_src_e     = ctrl_e.res_src;
    assign mem_write_e   = ctrl_e.mem_write;
    assign jump_e        = ctrl_e.jump;
    assign branch_e      = ctrl_e.branch;
    assign alu_src_a_e   = ctrl_e.alu_src_a;
    assign alu_src_b_e   = ctrl_e.alu_src_b;
    assign adder_src_e   = ctrl_e.adder_src;
    assign alu_control_e = ALU_CTRL_W'(ctrl_e.alu);
    assign illegal_e     = ctrl_e.illegal;

endmodule

// File: doc/md_control_unit.md
Name: md_control_unit

Overview:
- Next-generation decode control unit for the pipelined RV32 core.
- Decodes op/funct3/funct7 into datapath controls and registers them into the ID/EX control register with valid, stall and flush handling.
- Adds sequencing of multi-cycle multiply/divide (M-extension) ops: a counter FSM holds the pipeline for a parametrised latency.
- Replaces the purely combinational decoder plus the separate control pipeline register.

Parameters:
- ALU_CTRL_W, 4, width of the ALU control field; must be >= 4, upper bits zero-extended.
- MUL_LAT, 2, execute cycles for MUL/MULH/MULHSU/MULHU; must be >= 1.
- DIV_LAT, 8, execute cycles for DIV/DIVU/REM/REMU; must be >= 1.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_d  in  1  decode-stage instruction valid.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- stall_e  in  1  hazard unit hold of the E register.
- flush_e  in  1  hazard unit bubble insert into E.
- imm_src_d  out  3  combinational immediate select, used in decode.
- busy_d  out  1  multi-cycle op in flight; stalls F/D and blocks E advance.
- valid_e  out  1  E-stage instruction valid.
- reg_write_e, mem_write_e, jump_e, branch_e, alu_src_a_e, alu_src_b_e, adder_src_e  out  1 each  registered controls.
- res_src_e  out  2  00 ALU, 01 memory, 10 PC+4, 11 muldiv result.
- alu_control_e  out  ALU_CTRL_W  ALU operation.
- md_start_e  out  1  one-cycle start pulse to the muldiv unit.
- md_op_e  out  3  funct3 of the M op.
- illegal_e  out  1  unsupported opcode reached E.

Behaviour:
- Main decode is combinational and x-free. Control bit order: reg_write, res_src, mem_write, jump, branch, alu_src_a, alu_src_b, adder_src, imm_src.
- Per-opcode controls:
  - load 0000011: 1_01_0_0_0_0_1_0_000
  - op-imm 0010011: 1_00_0_0_0_0_1_0_000
  - auipc 0010111: 1_00_0_0_0_1_1_0_100
  - store 0100011: 0_01_1_0_0_0_1_0_001
  - op 0110011: 1_00_0_0_0_0_0_0_000
  - lui 0110111: 1_00_0_0_0_0_0_0_100
  - branch 1100011: 0_00_0_0_1_0_0_0_010
  - jalr 1100111: 1_10_0_1_0_0_0_1_000
  - jal 1101111: 1_10_0_1_0_0_0_0_011
  - Other opcodes: all zero, with illegal flagged.
- ALU codes:
  - add 0000; sub 0001 (op 0110011 and funct7[5] only); sll 0010; slt 0011; sltu 0100; xor 0101; srl 0110; sra 0111; or 1000; and 1001.
  - beq/bne 1010; blt/bge 1011; bltu/bgeu 1100; lui 1101.
  - load, store, auipc: 0000. jal, jalr: 0000.
  - Branch funct3 01x selects 1010 and is flagged illegal.
- M op: op 0110011 with funct7 = 0000001. Sets res_src 11 and md_op = funct3. funct3[2]=1 selects DIV_LAT, otherwise MUL_LAT.
- E register update priority, evaluated each rising edge:
  1. rst (async): all outputs 0, FSM IDLE, counter 0.
  2. flush_e: bubble (valid_e, all write enables and md_start_e 0). Aborts any M op; FSM returns to IDLE.
  3. stall_e or busy_d: E holds; md_start_e forced 0.
  4. Otherwise: load decoded controls. valid_e = valid_d. Controls gated to 0 when valid_d = 0. illegal_e = valid_d & unsupported.
- FSM states IDLE and MD_BUSY; counter width clog2(max(MUL_LAT, DIV_LAT)).
  - IDLE: a valid M op loaded into E sets md_start_e = 1 for exactly one cycle.
  - If LAT > 1: counter = LAT-1, go to MD_BUSY. If LAT = 1: stay in IDLE.
  - MD_BUSY: busy_d = 1; counter decrements each cycle not under flush.
  - When counter = 1 and decrements, the next state is IDLE, so busy_d is high for exactly LAT-1 cycles after issue.
  - stall_e does not pause the counter.
- busy_d is a registered state decode: 0 after reset, with no combinational path from inputs.
- Back-to-back M ops: the second issues in the first cycle after busy_d falls.

Optional Feature:
- Macro RV_M_EXT_EN.
- Defined: M-op detection, res_src 11, md_* outputs and the FSM are built as described.
- Undefined: funct7 = 0000001 on op 0110011 is treated as illegal (bubble controls, illegal_e = 1). md_start_e, md_op_e and busy_d are tied to 0. No FSM logic is synthesised.

Test Plan:
- Reset asserted mid-MD_BUSY (DIV_LAT=8, 3 cycles in) -> all outputs 0 and busy_d 0 immediately, without waiting for a clock edge.
- sub (op 0110011, funct3 000, funct7 0100000), then addi with funct7[5]=1 -> alu_control_e 0001, then 0000; reg_write_e 1 both cycles.
- DIV (funct3 100, funct7 0000001), DIV_LAT=8 -> md_start_e high 1 cycle, busy_d high 7 cycles, E holds md_op_e 100, next instr loads on cycle 8.
- MUL with MUL_LAT=1 -> md_start_e 1 cycle, busy_d never asserts, following add loads next cycle.
- flush_e asserted 2 cycles into a DIV -> valid_e 0, reg_write_e 0, busy_d 0 next cycle, FSM IDLE.
- Opcode 1111111 with valid_d 1, and RV_M_EXT_EN undefined with MUL encoding -> illegal_e 1, all write enables 0; stall_e high holds every E output unchanged.
